// File: rtl/fetch_pc_unit_pkg.sv
// Shared constants and the 2-bit saturating counter rule for the fetch PC unit.
// Default parameter values mirror the system-wide PC/BTB definitions.
package fetch_pc_unit_pkg;

    localparam int unsigned PC_WIDTH_DEF  = 32;
    localparam int unsigned IDX_WIDTH_DEF = 6;
    localparam int unsigned CNT_WIDTH_DEF = 16;
    localparam logic [31:0] RESET_PC_DEF  = '0;

    typedef enum logic [1:0] {
        PHT_STRONG_NT = 2'b00,
        PHT_WEAK_NT   = 2'b01,
        PHT_WEAK_T    = 2'b10,
        PHT_STRONG_T  = 2'b11
    } pht_state_e;

    localparam logic [1:0] PHT_INIT_DEF = PHT_WEAK_NT;

    // Saturating step: taken moves toward strong-taken, not-taken toward strong-not-taken.
    function automatic logic [1:0] pht_next(input logic [1:0] cur, input logic taken);
        if (taken) begin
            return (cur == PHT_STRONG_T) ? cur : cur + 2'd1;
        end
        return (cur == PHT_STRONG_NT) ? cur : cur - 2'd1;
    endfunction

endpackage

// File: rtl/fetch_pc_unit_pht.sv
// Pattern history table: 2-bit saturating counters, one combinational read port
// (direction bit only) and one synchronous update port.
module pht_2bit
    import fetch_pc_unit_pkg::*;
#(
    parameter int unsigned IDX_WIDTH = IDX_WIDTH_DEF,
    parameter logic [1:0]  PHT_INIT  = PHT_INIT_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IDX_WIDTH-1:0] rd_idx,
    output logic                 rd_taken,
    input  logic                 upd_en,
    input  logic [IDX_WIDTH-1:0] upd_idx,
    input  logic                 upd_taken
);

    localparam int unsigned ENTRIES = 1 << IDX_WIDTH;

    logic [1:0] cnt [ENTRIES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                cnt[i] <= PHT_INIT;
            end
        end else if (upd_en) begin
            cnt[upd_idx] <= pht_next(cnt[upd_idx], upd_taken);
        end
    end

    // Read sees the pre-update value when it collides with a same-cycle write.
    assign rd_taken = cnt[rd_idx][1];

endmodule

// File: rtl/fetch_pc_unit.sv
// IF-stage next-PC generator: PC register, BTB+PHT prediction, EX-stage
// mispredict detection/redirect, BTB write outputs and mispredict counter.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int unsigned          PC_WIDTH  = PC_WIDTH_DEF,
    parameter int unsigned          IDX_WIDTH = IDX_WIDTH_DEF,
    parameter logic [PC_WIDTH-1:0]  RESET_PC  = '0,
    parameter logic [1:0]           PHT_INIT  = PHT_INIT_DEF,
    parameter int unsigned          CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 Stall,
    output logic [PC_WIDTH-1:0]  IF_PC,
    output logic [IDX_WIDTH-1:0] PC_Tag,
    input  logic [PC_WIDTH-1:0]  BTB_PC,
    input  logic                 BTB_Valid,
    output logic                 IF_Pred_Taken,
    output logic [PC_WIDTH-1:0]  IF_Pred_PC,
    input  logic                 EX_Branch,
    input  logic [PC_WIDTH-1:0]  EX_PC,
    input  logic                 EX_Taken,
    input  logic [PC_WIDTH-1:0]  EX_Target,
    input  logic                 EX_Pred_Taken,
    input  logic [PC_WIDTH-1:0]  EX_Pred_PC,
    output logic [IDX_WIDTH-1:0] EX_PC_Tag,
    output logic [PC_WIDTH-1:0]  Branch_PC,
    output logic                 Branch_Taken,
    output logic                 Flush,
    output logic [CNT_WIDTH-1:0] Mispredict_Cnt
);

    logic                pht_taken;
    logic                mispredict;
    logic [PC_WIDTH-1:0] correct_pc;
    logic [PC_WIDTH-1:0] next_pc;

    assign PC_Tag    = IF_PC[IDX_WIDTH+1:2];
    assign EX_PC_Tag = EX_PC[IDX_WIDTH+1:2];

    pht_2bit #(
        .IDX_WIDTH (IDX_WIDTH),
        .PHT_INIT  (PHT_INIT)
    ) u_pht (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (PC_Tag),
        .rd_taken  (pht_taken),
        .upd_en    (EX_Branch),
        .upd_idx   (EX_PC_Tag),
        .upd_taken (EX_Taken)
    );

    assign IF_Pred_Taken = BTB_Valid & pht_taken;
    assign IF_Pred_PC    = IF_Pred_Taken ? BTB_PC : IF_PC + PC_WIDTH'(4);

    assign mispredict = EX_Branch &
                        ((EX_Taken != EX_Pred_Taken) | (EX_Taken & (EX_Target != EX_Pred_PC)));
    assign correct_pc = EX_Taken ? EX_Target : EX_PC + PC_WIDTH'(4);

    // Outputs that act on neighbouring stages are held quiet while in reset.
    assign Flush        = mispredict & rst_n;
    assign Branch_Taken = EX_Branch & EX_Taken & rst_n;
    assign Branch_PC    = EX_Target;

    always_comb begin
        next_pc = IF_Pred_PC;
        if (mispredict) begin
            next_pc = correct_pc;
        end else if (Stall) begin
            next_pc = IF_PC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            IF_PC          <= RESET_PC;
            Mispredict_Cnt <= '0;
        end else begin
            IF_PC <= next_pc;
            if (mispredict && (Mispredict_Cnt != '1)) begin
                Mispredict_Cnt <= Mispredict_Cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule
